// File: rtl/msu_sector_arbiter_if.sv
// Client, host and status signals of the MSU1 sector-fetch arbiter.
// The arbiter attaches through the slave modport; clients and host drive the master side.
interface msu_sector_arbiter_if;
    logic        aud_req;
    logic        aud_seek;
    logic [21:0] aud_sector;
    logic        aud_abort;
    logic        aud_ack;
    logic        aud_download;
    logic        aud_data_wr;

    logic        dat_req;
    logic        dat_seek;
    logic [21:0] dat_sector;
    logic        dat_ack;
    logic        dat_download;
    logic        dat_data_wr;

    logic [15:0] xfer_data;

    logic        sd_req;
    logic        sd_seek;
    logic [21:0] sd_sector;
    logic        sd_target;
    logic        sd_ack;
    logic        sd_download;
    logic        sd_data_wr;
    logic [15:0] sd_data;

    logic        short_sector;
    logic        timeout_err;

    modport slave (
        input  aud_req, aud_seek, aud_sector, aud_abort,
        input  dat_req, dat_seek, dat_sector,
        input  sd_ack, sd_download, sd_data_wr, sd_data,
        output aud_ack, aud_download, aud_data_wr,
        output dat_ack, dat_download, dat_data_wr,
        output xfer_data, sd_req, sd_seek, sd_sector, sd_target,
        output short_sector, timeout_err
    );

    modport master (
        output aud_req, aud_seek, aud_sector, aud_abort,
        output dat_req, dat_seek, dat_sector,
        output sd_ack, sd_download, sd_data_wr, sd_data,
        input  aud_ack, aud_download, aud_data_wr,
        input  dat_ack, dat_download, dat_data_wr,
        input  xfer_data, sd_req, sd_seek, sd_sector, sd_target,
        input  short_sector, timeout_err
    );
endinterface

// File: rtl/msu_sector_arbiter.sv
// Round-robin arbiter sharing the host sector-fetch channel between MSU1 audio and data clients.
// Define MSU_ARB_TIMEOUT_EN to enable the watchdog that abandons a request stuck waiting for sd_ack.
module msu_sector_arbiter #(
    parameter int          SECTOR_WORDS   = 512,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input logic                 clk,
    input logic                 reset_n,
    msu_sector_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    localparam logic [9:0] CNT_MAX  = 10'h3FF;
    localparam logic [9:0] FULL_CNT = 10'(SECTOR_WORDS);

    state_t      state_q, state_d;
    logic        sd_req_q, sd_req_d;
    logic        sd_seek_q, sd_seek_d;
    logic        sd_target_q, sd_target_d;
    logic [21:0] sd_sector_q, sd_sector_d;
    logic        last_grant_q, last_grant_d;
    logic        short_q, short_d;
    logic        ack_q;
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  cnt_inc;
    logic        aud_p, dat_p, grant_dat;
    logic        abort_now, route_en, word_stb, ack_fall, tmo_hit;

`ifdef MSU_ARB_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        tmo_err_q, tmo_err_d;

    assign tmo_hit         = (tmo_q == TIMEOUT_CYCLES - 32'd1);
    assign bus.timeout_err = tmo_err_q;
`else
    assign tmo_hit         = 1'b0 & (TIMEOUT_CYCLES != 32'd0);
    assign bus.timeout_err = 1'b0;
`endif

    assign aud_p     = (bus.aud_req | bus.aud_seek) & ~bus.aud_abort;
    assign dat_p     = bus.dat_req | bus.dat_seek;
    // last_grant = 1 means data was served last, so audio wins a tie
    assign grant_dat = dat_p & (~aud_p | ~last_grant_q);

    assign abort_now = (state_q == ISSUE) & ~sd_target_q & bus.aud_abort;
    assign route_en  = reset_n & ((state_q == ISSUE) | (state_q == XFER)) & ~abort_now;
    assign word_stb  = route_en & bus.sd_download & bus.sd_data_wr;
    assign ack_fall  = ack_q & ~bus.sd_ack;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 10'd1;

    assign bus.aud_ack      = route_en & ~sd_target_q & bus.sd_ack;
    assign bus.aud_download = route_en & ~sd_target_q & bus.sd_download;
    assign bus.aud_data_wr  = route_en & ~sd_target_q & bus.sd_data_wr;
    assign bus.dat_ack      = route_en &  sd_target_q & bus.sd_ack;
    assign bus.dat_download = route_en &  sd_target_q & bus.sd_download;
    assign bus.dat_data_wr  = route_en &  sd_target_q & bus.sd_data_wr;
    assign bus.xfer_data    = bus.sd_data;

    assign bus.sd_req       = sd_req_q;
    assign bus.sd_seek      = sd_seek_q;
    assign bus.sd_sector    = sd_sector_q;
    assign bus.sd_target    = sd_target_q;
    assign bus.short_sector = short_q;

    always_comb begin
        state_d      = state_q;
        sd_req_d     = sd_req_q;
        sd_seek_d    = sd_seek_q;
        sd_target_d  = sd_target_q;
        sd_sector_d  = sd_sector_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        short_d      = 1'b0;
`ifdef MSU_ARB_TIMEOUT_EN
        tmo_d        = 32'd0;
        tmo_err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = 10'd0;
                if (aud_p | dat_p) begin
                    sd_target_d = grant_dat;
                    sd_sector_d = grant_dat ? bus.dat_sector : bus.aud_sector;
                    sd_seek_d   = grant_dat ? bus.dat_seek   : bus.aud_seek;
                    sd_req_d    = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (word_stb) cnt_d = cnt_inc;
                if (abort_now) begin
                    sd_req_d = 1'b0;
                    state_d  = DONE;
                end else if (bus.sd_ack) begin
                    sd_req_d = 1'b0;
                    state_d  = XFER;
                end else if (tmo_hit) begin
                    sd_req_d     = 1'b0;
                    last_grant_d = sd_target_q;
                    state_d      = IDLE;
`ifdef MSU_ARB_TIMEOUT_EN
                    tmo_err_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
`endif
                end
            end
            XFER: begin
                if (word_stb) cnt_d = cnt_inc;
                if (ack_fall) begin
                    short_d = (cnt_d != FULL_CNT);
                    state_d = DONE;
                end
            end
            DONE: begin
                last_grant_d = sd_target_q;
                cnt_d        = 10'd0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sd_req_q     <= 1'b0;
            sd_seek_q    <= 1'b0;
            sd_target_q  <= 1'b0;
            sd_sector_q  <= 22'd0;
            last_grant_q <= 1'b1;
            short_q      <= 1'b0;
            ack_q        <= 1'b0;
            cnt_q        <= 10'd0;
        end else begin
            state_q      <= state_d;
            sd_req_q     <= sd_req_d;
            sd_seek_q    <= sd_seek_d;
            sd_target_q  <= sd_target_d;
            sd_sector_q  <= sd_sector_d;
            last_grant_q <= last_grant_d;
            short_q      <= short_d;
            ack_q        <= bus.sd_ack;
            cnt_q        <= cnt_d;
        end
    end

`ifdef MSU_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_q     <= 32'd0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
        end
    end
`endif
endmodule

// File: tb/tb_msu_sector_arbiter.sv
// Directed bench for msu_sector_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_msu_sector_arbiter;
    logic clk;
    logic reset_n;

    msu_sector_arbiter_if bus ();

    msu_sector_arbiter #(
        .SECTOR_WORDS  (512),
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ar, as;
        logic [21:0] asec;
        logic        ab, dr, ds;
        logic [21:0] dsec;
        logic        ack, dl, wr;
        logic [15:0] d;
        logic        ereq, eseek, etgt;
        logic [21:0] esec;
        logic [5:0]  eroute;
        logic        eshort;
    } vec_t;

    vec_t vecs[21];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic ar, input logic as, input logic [21:0] asec,
                                input logic ab, input logic dr, input logic ds,
                                input logic [21:0] dsec, input logic ack, input logic dl,
                                input logic wr, input logic [15:0] d, input logic ereq,
                                input logic eseek, input logic etgt, input logic [21:0] esec,
                                input logic [5:0] eroute, input logic eshort);
        vec_t v;
        v.ar = ar; v.as = as; v.asec = asec; v.ab = ab;
        v.dr = dr; v.ds = ds; v.dsec = dsec;
        v.ack = ack; v.dl = dl; v.wr = wr; v.d = d;
        v.ereq = ereq; v.eseek = eseek; v.etgt = etgt; v.esec = esec;
        v.eroute = eroute; v.eshort = eshort;
        return v;
    endfunction

    function automatic logic [48:0] outs();
        return {bus.sd_req, bus.sd_seek, bus.sd_target, bus.sd_sector,
                bus.aud_ack, bus.aud_download, bus.aud_data_wr,
                bus.dat_ack, bus.dat_download, bus.dat_data_wr,
                bus.short_sector, bus.timeout_err, bus.xfer_data};
    endfunction

    function automatic logic [48:0] expv(input vec_t v);
        return {v.ereq, v.eseek, v.etgt, v.esec, v.eroute, v.eshort, 1'b0, v.d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        bus.aud_req = v.ar; bus.aud_seek = v.as; bus.aud_sector = v.asec; bus.aud_abort = v.ab;
        bus.dat_req = v.dr; bus.dat_seek = v.ds; bus.dat_sector = v.dsec;
        bus.sd_ack = v.ack; bus.sd_download = v.dl; bus.sd_data_wr = v.wr; bus.sd_data = v.d;
    endtask

    task automatic host(input logic ack, input logic dl, input logic wr);
        bus.sd_ack = ack; bus.sd_download = dl; bus.sd_data_wr = wr;
    endtask

    function automatic logic [6:0] req_routes();
        return {bus.sd_req, bus.aud_ack, bus.aud_download, bus.aud_data_wr,
                bus.dat_ack, bus.dat_download, bus.dat_data_wr};
    endfunction

    initial begin
        int   cnt;
        int   pulses;
        logic other_any;
        logic short_seen;
        logic req_ok;
        logic tmo_any;

        vecs[0]  = mk(0,0,0,0, 0,0,0, 0,0,0,16'h1234, 0,0,0,0, 6'b000000,0);
        vecs[1]  = mk(1,0,5,0, 1,0,9, 0,0,0,16'h0000, 0,0,0,0, 6'b000000,0);
        vecs[2]  = mk(1,0,5,0, 1,0,9, 0,0,0,16'h0000, 1,0,0,5, 6'b000000,0);
        vecs[3]  = mk(1,0,5,0, 1,0,9, 1,0,0,16'h0000, 1,0,0,5, 6'b100000,0);
        vecs[4]  = mk(0,0,5,0, 1,0,9, 1,1,1,16'hAAAA, 0,0,0,5, 6'b111000,0);
        vecs[5]  = mk(0,0,5,0, 1,0,9, 1,1,0,16'hBBBB, 0,0,0,5, 6'b110000,0);
        vecs[6]  = mk(0,0,5,0, 1,0,9, 1,1,1,16'hCCCC, 0,0,0,5, 6'b111000,0);
        vecs[7]  = mk(0,0,5,0, 1,0,9, 0,0,0,16'h0000, 0,0,0,5, 6'b000000,0);
        vecs[8]  = mk(0,0,5,0, 1,0,9, 0,0,0,16'h0000, 0,0,0,5, 6'b000000,1);
        vecs[9]  = mk(0,0,7,0, 1,0,9, 0,0,0,16'h0000, 0,0,0,5, 6'b000000,0);
        vecs[10] = mk(1,0,7,0, 1,0,9, 0,0,0,16'h0000, 1,0,1,9, 6'b000000,0);
        vecs[11] = mk(1,0,7,0, 1,0,9, 1,1,1,16'h5555, 1,0,1,9, 6'b000111,0);
        vecs[12] = mk(1,0,7,0, 0,0,9, 0,0,0,16'h0000, 0,0,1,9, 6'b000000,0);
        vecs[13] = mk(1,0,7,0, 1,0,9, 0,0,0,16'h0000, 0,0,1,9, 6'b000000,1);
        vecs[14] = mk(1,0,7,0, 1,0,9, 0,0,0,16'h0000, 0,0,1,9, 6'b000000,0);
        vecs[15] = mk(1,0,7,0, 1,0,9, 0,0,0,16'h0000, 1,0,0,7, 6'b000000,0);
        vecs[16] = mk(1,0,7,1, 0,0,9, 0,0,0,16'h0000, 1,0,0,7, 6'b000000,0);
        vecs[17] = mk(1,0,7,1, 0,0,9, 0,0,0,16'h0000, 0,0,0,7, 6'b000000,0);
        vecs[18] = mk(1,0,7,1, 0,0,9, 0,0,0,16'h0000, 0,0,0,7, 6'b000000,0);
        vecs[19] = mk(0,0,7,0, 0,0,9, 1,1,1,16'h0F0F, 0,0,0,7, 6'b000000,0);
        vecs[20] = mk(0,0,7,0, 0,0,9, 0,0,0,16'h0000, 0,0,0,7, 6'b000000,0);

        reset_n = 1'b0;
        apply(vecs[20]);
        bus.aud_sector = 22'd0;
        bus.dat_sector = 22'd0;
        repeat (3) cyc();
        samp();
        check("reset_state", 64'(outs()), 64'd0);

        for (int i = 0; i < 21; i++) begin
            cyc();
            reset_n = 1'b1;
            apply(vecs[i]);
            samp();
            check($sformatf("vec%0d", i), 64'(outs()), 64'(expv(vecs[i])));
        end

        // Full 512-word audio seek transfer
        cyc(); bus.aud_seek = 1'b1; bus.aud_sector = 22'd0; samp();
        cyc(); samp();
        check("seek_issue", 64'({bus.sd_req, bus.sd_seek, bus.sd_target, bus.sd_sector}),
              64'({1'b1, 1'b1, 1'b0, 22'd0}));
        cyc(); host(1, 0, 0); bus.aud_seek = 1'b0; samp();
        cnt = 0; other_any = 1'b0; short_seen = 1'b0;
        for (int i = 0; i < 512; i++) begin
            cyc(); host(1, 1, 1); bus.sd_data = 16'(i); samp();
            if (bus.aud_data_wr) cnt++;
            other_any |= bus.dat_ack | bus.dat_download | bus.dat_data_wr;
            short_seen |= bus.short_sector;
        end
        for (int i = 0; i < 4; i++) begin
            cyc(); host(0, 0, 0); samp();
            short_seen |= bus.short_sector;
        end
        check("full_aud_words", 64'(cnt), 64'd512);
        check("full_dat_quiet", 64'(other_any), 64'd0);
        check("full_no_short", 64'(short_seen), 64'd0);

        // 300-word data transfer ends short
        cyc(); bus.dat_req = 1'b1; bus.dat_sector = 22'd77; samp();
        cyc(); samp();
        check("short_issue", 64'({bus.sd_req, bus.sd_target, bus.sd_sector}),
              64'({1'b1, 1'b1, 22'd77}));
        cyc(); host(1, 0, 0); bus.dat_req = 1'b0; samp();
        cnt = 0; other_any = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc(); host(1, 1, 1); samp();
            if (bus.dat_data_wr) cnt++;
            other_any |= bus.aud_ack | bus.aud_download | bus.aud_data_wr;
        end
        cyc(); host(0, 0, 0); samp();
        check("short_not_early", 64'(bus.short_sector), 64'd0);
        cyc(); samp();
        check("short_pulse", 64'(bus.short_sector), 64'd1);
        pulses = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(); samp();
            if (bus.short_sector) pulses++;
        end
        check("short_once", 64'(pulses), 64'd1);
        check("short_dat_words", 64'(cnt), 64'd300);
        check("short_aud_quiet", 64'(other_any), 64'd0);

        // Data request never acknowledged by the host
        cyc(); bus.dat_req = 1'b1; bus.dat_sector = 22'd3; samp();
`ifdef MSU_ARB_TIMEOUT_EN
        req_ok = 1'b1; tmo_any = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            if (i == 100) bus.dat_req = 1'b0;
            samp();
            req_ok &= bus.sd_req;
            tmo_any |= bus.timeout_err;
        end
        check("tmo_wait", 64'({req_ok, tmo_any}), 64'({1'b1, 1'b0}));
        cyc(); samp();
        check("tmo_fire", 64'({bus.sd_req, bus.timeout_err}), 64'({1'b0, 1'b1}));
        cyc(); samp();
        check("tmo_pulse_end", 64'({bus.sd_req, bus.timeout_err}), 64'd0);
`else
        req_ok = 1'b1; tmo_any = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            cyc(); samp();
            req_ok &= bus.sd_req;
            tmo_any |= bus.timeout_err;
        end
        check("hold_wait", 64'({req_ok, tmo_any}), 64'({1'b1, 1'b0}));
        cyc(); host(1, 0, 0); bus.dat_req = 1'b0; samp();
        check("hold_ack", 64'({bus.dat_ack, bus.aud_ack}), 64'({1'b1, 1'b0}));
        cyc(); host(0, 0, 0); samp();
        cyc(); samp();
        check("hold_empty_short", 64'(bus.short_sector), 64'd1);
`endif
        repeat (2) begin cyc(); samp(); end

        // Reset in the middle of an audio transfer
        cyc(); bus.aud_req = 1'b1; bus.aud_sector = 22'd12; samp();
        cyc(); host(1, 0, 0); bus.aud_req = 1'b0; samp();
        for (int i = 0; i < 200; i++) begin
            cyc(); host(1, 1, 1); samp();
        end
        cyc(); reset_n = 1'b0; samp();
        check("rst_during", 64'(req_routes()), 64'd0);
        cyc(); reset_n = 1'b1; samp();
        check("rst_after", 64'(req_routes()), 64'd0);
        cyc(); host(0, 0, 0); bus.aud_req = 1'b1; bus.aud_sector = 22'd33; samp();
        cyc(); samp();
        check("rst_reissue", 64'({bus.sd_req, bus.sd_target, bus.sd_sector}),
              64'({1'b1, 1'b0, 22'd33}));
        cyc(); host(1, 0, 0); bus.aud_req = 1'b0; samp();
        check("rst_reissue_ack", 64'({bus.aud_ack, bus.dat_ack}), 64'({1'b1, 1'b0}));
        cyc(); host(0, 0, 0); samp();
        repeat (3) begin cyc(); samp(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
